// File: rtl/vm80a_intc.sv
// Vectored interrupt controller for a VM80A (8080-class) CPU: per-channel edge/level
// requests, mask, fixed or rotating priority, an internal periodic timer, and RST-vector generation.
module vm80a_intc #(
    parameter int NCH   = 8,
    parameter int VBASE = 4,
    parameter int TDIV  = 50000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] irq_i,
    input  logic           sync,
    input  logic [7:0]     stat_i,
    output logic           int_o,
    output logic [7:0]     vec_o,
    output logic           inta_o,
    input  logic [1:0]     reg_a,
    input  logic           reg_wr,
    input  logic [7:0]     reg_d,
    output logic [7:0]     reg_q
);

    localparam int CW = (TDIV > 1) ? $clog2(TDIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TDIV - 1);

    localparam logic [1:0] A_MASK = 2'd0;
    localparam logic [1:0] A_PEND = 2'd1;
    localparam logic [1:0] A_EDGE = 2'd2;
    localparam logic [1:0] A_CTL  = 2'd3;

    logic [NCH-1:0] mask;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] edge_sel;
    logic [1:0]     ctl;
    logic [NCH-1:0] irq_prev;
    logic [CW-1:0]  cnt;
    logic [2:0]     ptr;

    logic           tick;
    logic           ack;
    logic           wr_mask;
    logic           wr_pend;
    logic           wr_edge;
    logic           wr_ctl;
    logic [NCH-1:0] cand;
    logic           win_found;
    logic [2:0]     win_idx;
    logic [2:0]     win_rst;
    logic [2:0]     ptr_nxt;
    logic [7:0]     vec_nxt;
    logic [NCH-1:0] set_b;
    logic [NCH-1:0] lvl_b;
    logic [NCH-1:0] clr_b;
    logic [NCH-1:0] pend_nxt;

    function automatic logic [7:0] ext8(input logic [NCH-1:0] v);
        logic [7:0] r;
        r = '0;
        r[NCH-1:0] = v;
        return r;
    endfunction

    assign tick    = ctl[1] && (cnt == CNT_MAX);
    // INTA protocol: an edge with sync=1 starts (stat_i[0]=1) or ends (stat_i[0]=0) the
    // acknowledge cycle; only a starting edge picks a winner and loads vec_o.
    assign ack     = sync && stat_i[0];
    assign wr_mask = reg_wr && (reg_a == A_MASK);
    assign wr_pend = reg_wr && (reg_a == A_PEND);
    assign wr_edge = reg_wr && (reg_a == A_EDGE);
    assign wr_ctl  = reg_wr && (reg_a == A_CTL);
    assign cand    = pend & mask;

    // Search starts at the rotation pointer in rotate mode, at channel 0 otherwise.
    always_comb begin
        int base;
        int c;
        win_found = 1'b0;
        win_idx   = '0;
        base      = ctl[0] ? int'(ptr) : 0;
        c         = 0;
        for (int i = 0; i < NCH; i++) begin
            c = (base + i) % NCH;
            if (!win_found && cand[c]) begin
                win_found = 1'b1;
                win_idx   = 3'(c);
            end
        end
    end

    assign win_rst = 3'((VBASE + int'(win_idx)) % 8);
    assign vec_nxt = 8'hC7 | {2'b00, win_rst, 3'b000};
    assign ptr_nxt = 3'((int'(win_idx) + 1) % NCH);

    // Set beats clear on the same bit; level channels simply follow the sampled line.
    always_comb begin
        set_b    = irq_i & ~irq_prev;
        set_b[0] = set_b[0] | tick;
        lvl_b    = irq_i;
        lvl_b[0] = lvl_b[0] | tick;
        clr_b    = '0;
        if (wr_pend) begin
            clr_b = reg_d[NCH-1:0];
        end
        for (int k = 0; k < NCH; k++) begin
            if (ack && win_found && (int'(win_idx) == k)) begin
                clr_b[k] = 1'b1;
            end
        end
        pend_nxt = '0;
        for (int k = 0; k < NCH; k++) begin
            if (edge_sel[k]) begin
                pend_nxt[k] = set_b[k] | (pend[k] & ~clr_b[k]);
            end else begin
                pend_nxt[k] = lvl_b[k];
            end
        end
    end

    always_comb begin
        reg_q = 8'h00;
        case (reg_a)
            A_MASK:  reg_q = ext8(mask);
            A_PEND:  reg_q = ext8(pend);
            A_EDGE:  reg_q = ext8(edge_sel);
            default: reg_q = {6'b0, ctl};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask     <= '0;
            pend     <= '0;
            edge_sel <= '1;
            ctl      <= '0;
            irq_prev <= '0;
            cnt      <= '0;
            ptr      <= '0;
            int_o    <= 1'b0;
            inta_o   <= 1'b0;
            vec_o    <= 8'hFF;
        end else begin
            irq_prev <= irq_i;
            pend     <= pend_nxt;

            if (!ctl[1] || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (wr_mask) mask     <= reg_d[NCH-1:0];
            if (wr_edge) edge_sel <= reg_d[NCH-1:0];
            if (wr_ctl)  ctl      <= reg_d[1:0];

            int_o <= (|cand) & ~inta_o;
            if (sync) begin
                inta_o <= stat_i[0];
            end

            // Spurious acknowledge returns RST 7 and leaves pointer and pending state alone.
            if (ack) begin
                if (win_found) begin
                    vec_o <= vec_nxt;
                    if (ctl[0]) begin
                        ptr <= ptr_nxt;
                    end
                end else begin
                    vec_o <= 8'hFF;
                end
            end
        end
    end

endmodule
